// File: rtl/dispatch_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dispatch_queue_if : decode->ooo bundle channel with core flow control  (rev 1.0)
// ---------------------------------------------------------------------------
interface dispatch_queue_if #(
   parameter int N = 2,
   parameter int W = 64
);
   logic           squash;
   logic           structural_hazard;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic           in_ready;
   logic [N-1:0]   out_valid;
   logic [N*W-1:0] out_data;

   modport master (
      output squash, structural_hazard, in_valid, in_data,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  squash, structural_hazard, in_valid, in_data,
      output in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/dispatch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dispatch_queue : N-wide in-order decode->ooo queue; DISPATCH_QUEUE_STATS_EN adds stall counter  (rev 1.0)
// ---------------------------------------------------------------------------
module dispatch_queue #(
   parameter int N     = 2,
   parameter int DEPTH = 8,
   parameter int W     = 64
) (
   input  logic            clock_i,
   input  logic            reset_i,
   dispatch_queue_if.slave dq
`ifdef DISPATCH_QUEUE_STATS_EN
   ,
   output logic [31:0]     stall_cycles_o
`endif
);
   localparam int            PW      = $clog2(DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_N     = CW'(N);

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    enq_cnt, deq_cnt;
   logic             accept;
   logic [DEPTH-1:0] we;
   logic [W-1:0]     wdata [DEPTH];
   logic [W-1:0]     mem   [DEPTH];

   // Readiness uses the pre-dequeue count, so it never depends on this cycle's inputs.
   assign dq.in_ready = !reset_i && ((C_DEPTH - count_q) >= C_N);
   assign accept      = dq.in_ready && !dq.squash;

   always_comb begin
      enq_cnt = '0;
      deq_cnt = '0;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      for (int i = 0; i < N; i++) begin
         enq_cnt = enq_cnt + CW'(dq.in_valid[i]);
      end
      if (!accept) begin
         enq_cnt = '0;
      end
      if (!dq.structural_hazard) begin
         deq_cnt = (count_q > C_N) ? C_N : count_q;
      end
      if (dq.squash) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(deq_cnt);
         tail_d  = tail_q + PW'(enq_cnt);
         count_d = count_q + enq_cnt - deq_cnt;
      end
   end

   // Lanes are contiguous, so lane i always lands at tail+i.
   always_comb begin
      we = '0;
      for (int e = 0; e < DEPTH; e++) begin
         wdata[e] = '0;
         for (int i = 0; i < N; i++) begin
            if (accept && dq.in_valid[i] && ((tail_q + PW'(i)) == PW'(e))) begin
               we[e]    = 1'b1;
               wdata[e] = dq.in_data[i*W +: W];
            end
         end
      end
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      logic [W-1:0] entry_q;
      always_ff @(posedge clock_i or posedge reset_i) begin
         if (reset_i) begin
            entry_q <= '0;
         end else if (we[e]) begin
            entry_q <= wdata[e];
         end
      end
      assign mem[e] = entry_q;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      dq.out_valid = '0;
      dq.out_data  = '0;
      for (int i = 0; i < N; i++) begin
         dq.out_valid[i]       = (count_q > CW'(i));
         dq.out_data[i*W +: W] = mem[head_q + PW'(i)];
      end
   end

`ifdef DISPATCH_QUEUE_STATS_EN
   logic [31:0] stall_q;
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         stall_q <= '0;
      end else if (dq.out_valid[0] && dq.structural_hazard && !dq.squash && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end
   assign stall_cycles_o = stall_q;
`endif

   logic [N-1:0] valid_inc;
   assign valid_inc = dq.in_valid + N'(1);

   a_contiguous_valid: assert property (@(posedge clock_i) disable iff (reset_i)
      accept |-> ((dq.in_valid & valid_inc) == '0));

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// tb_dispatch_queue : scenario tasks plus randomized traffic against a queue-based reference model.
module tb_dispatch_queue;
   localparam int N     = 2;
   localparam int DEPTH = 8;
   localparam int W     = 64;

   logic        clock_i = 1'b0;
   logic        reset_i;
   int          errors = 0;
   int          checks = 0;
   logic [W-1:0] mq[$];
   longint unsigned stall_model = 0;

   dispatch_queue_if #(.N(N), .W(W)) dq_if ();

`ifdef DISPATCH_QUEUE_STATS_EN
   logic [31:0] stall_cycles;
`endif

   dispatch_queue #(.N(N), .DEPTH(DEPTH), .W(W)) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .dq      (dq_if)
`ifdef DISPATCH_QUEUE_STATS_EN
      ,
      .stall_cycles_o (stall_cycles)
`endif
   );

   always #5 clock_i = ~clock_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [N-1:0] exp_valid();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = (i < mq.size());
      return v;
   endfunction

   function automatic logic [N*W-1:0] exp_data();
      logic [N*W-1:0] d = '0;
      for (int i = 0; i < N; i++) if (i < mq.size()) d[i*W +: W] = mq[i];
      return d;
   endfunction

   function automatic logic [N*W-1:0] masked(input logic [N*W-1:0] d, input logic [N-1:0] v);
      logic [N*W-1:0] r = '0;
      for (int i = 0; i < N; i++) if (v[i]) r[i*W +: W] = d[i*W +: W];
      return r;
   endfunction

   function automatic logic [W-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic drive(input logic sq, input logic hz, input logic [N-1:0] iv, input logic [N*W-1:0] id);
      dq_if.squash            = sq;
      dq_if.structural_hazard = hz;
      dq_if.in_valid          = iv;
      dq_if.in_data           = id;
   endtask

   // Advance the model by one edge using the inputs currently driven, then step the DUT.
   task automatic tick();
      bit rdy = ((DEPTH - mq.size()) >= N);
      if (mq.size() > 0 && dq_if.structural_hazard && !dq_if.squash && stall_model != 64'hFFFF_FFFF)
         stall_model++;
      if (dq_if.squash) begin
         mq.delete();
      end else begin
         if (!dq_if.structural_hazard)
            for (int i = 0; i < N; i++) if (mq.size() > 0) void'(mq.pop_front());
         if (rdy)
            for (int i = 0; i < N; i++) if (dq_if.in_valid[i]) mq.push_back(dq_if.in_data[i*W +: W]);
      end
      @(posedge clock_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      drive(1'b0, 1'b0, '0, '0);
      #12;
      checks++;
      if (dq_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %b expected 0", dq_if.in_ready); end
      checks++;
      if (dq_if.out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", dq_if.out_valid); end
      checks++;
      if (dq_if.out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", dq_if.out_data); end
      @(posedge clock_i);
      #1;
      reset_i = 1'b0;
      mq.delete();
      stall_model = 0;
      #1;
      checks++;
      if (dq_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", dq_if.in_ready); end
      checks++;
      if (dq_if.out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid_after: got %b expected 00", dq_if.out_valid); end
`ifdef DISPATCH_QUEUE_STATS_EN
      checks++;
      if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stalls: got %0d expected 0", stall_cycles); end
`endif
   endtask

   task automatic test_fill_and_hold();
      logic [W-1:0] p [8];
      for (int k = 0; k < 8; k++) p[k] = rnd64();
      for (int b = 0; b < 4; b++) begin
         drive(1'b0, 1'b1, 2'b11, {p[2*b+1], p[2*b]});
         tick();
         checks++;
         if (dq_if.in_ready !== (b < 3)) begin
            errors++; $display("FAIL fill_ready[%0d]: got %b expected %b", b, dq_if.in_ready, (b < 3));
         end
      end
      checks++;
      if (dq_if.out_valid !== 2'b11 || dq_if.out_data !== {p[1], p[0]}) begin
         errors++; $display("FAIL fill_head: got %b/%h expected 11/%h", dq_if.out_valid, dq_if.out_data, {p[1], p[0]});
      end
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b1, 2'b11, {rnd64(), rnd64()});
         tick();
         checks++;
         if (dq_if.out_valid !== 2'b11 || dq_if.out_data !== {p[1], p[0]} || dq_if.in_ready !== 1'b0) begin
            errors++; $display("FAIL hold[%0d]: got %b/%h rdy=%b expected 11/%h rdy=0",
                                c, dq_if.out_valid, dq_if.out_data, dq_if.in_ready, {p[1], p[0]});
         end
      end
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 1'b0, 2'b00, '0);
         tick();
         checks++;
         if (dq_if.out_valid !== (c < 3 ? 2'b11 : 2'b00) ||
             masked(dq_if.out_data, dq_if.out_valid) !== (c < 3 ? {p[2*c+3], p[2*c+2]} : '0)) begin
            errors++; $display("FAIL drain[%0d]: got %b/%h", c, dq_if.out_valid, dq_if.out_data);
         end
      end
   endtask

   task automatic test_single_lane();
      logic [W-1:0] x = rnd64();
      drive(1'b0, 1'b0, 2'b01, {64'd0, x});
      tick();
      drive(1'b0, 1'b0, 2'b00, '0);
      checks++;
      if (dq_if.out_valid !== 2'b01 || dq_if.out_data[W-1:0] !== x) begin
         errors++; $display("FAIL single_lane: got %b/%h expected 01/%h", dq_if.out_valid, dq_if.out_data[W-1:0], x);
      end
      tick();
      checks++;
      if (dq_if.out_valid !== 2'b00) begin errors++; $display("FAIL single_drain: got %b expected 00", dq_if.out_valid); end
   endtask

   task automatic test_squash();
      logic [W-1:0] y = rnd64();
      drive(1'b0, 1'b1, 2'b11, {rnd64(), rnd64()}); tick();
      drive(1'b0, 1'b1, 2'b11, {rnd64(), rnd64()}); tick();
      drive(1'b0, 1'b1, 2'b01, {rnd64(), rnd64()}); tick();
      drive(1'b1, 1'b0, 2'b11, {rnd64(), rnd64()}); tick();
      drive(1'b0, 1'b1, 2'b00, '0);
      checks++;
      if (dq_if.out_valid !== 2'b00 || dq_if.in_ready !== 1'b1) begin
         errors++; $display("FAIL squash: got valid=%b rdy=%b expected 00/1", dq_if.out_valid, dq_if.in_ready);
      end
      drive(1'b0, 1'b1, 2'b01, {64'd0, y}); tick();
      checks++;
      if (dq_if.out_valid !== 2'b01 || dq_if.out_data[W-1:0] !== y) begin
         errors++; $display("FAIL post_squash: got %b/%h expected 01/%h", dq_if.out_valid, dq_if.out_data[W-1:0], y);
      end
      drive(1'b0, 1'b0, 2'b00, '0); tick();
   endtask

   task automatic test_stream();
      logic [W-1:0] sent[$];
      logic [W-1:0] got[$];
      logic [W-1:0] lo = rnd64();
      logic [W-1:0] hi = rnd64();
      int accepted = 0;
      int cyc = 0;
      while (got.size() < 20 && cyc < 200) begin
         drive(1'b0, (cyc % 2 == 0), (accepted < 10) ? 2'b11 : 2'b00, {hi, lo});
         if (!dq_if.structural_hazard)
            for (int i = 0; i < N; i++) if (dq_if.out_valid[i]) got.push_back(dq_if.out_data[i*W +: W]);
         if (accepted < 10 && dq_if.in_ready) begin
            sent.push_back(lo); sent.push_back(hi);
            accepted++;
            lo = rnd64(); hi = rnd64();
         end
         tick();
         cyc++;
      end
      checks++;
      if (got.size() != 20) begin errors++; $display("FAIL stream_count: got %0d expected 20", got.size()); end
      for (int i = 0; i < 20; i++) begin
         if (i < got.size() && i < sent.size()) begin
            checks++;
            if (got[i] !== sent[i]) begin errors++; $display("FAIL stream_order[%0d]: got %h expected %h", i, got[i], sent[i]); end
         end
      end
      drive(1'b0, 1'b0, 2'b00, '0);
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         int sel = $urandom_range(0, 2);
         drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 3),
               (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11, {rnd64(), rnd64()});
         tick();
         checks++;
         if (dq_if.out_valid !== exp_valid()) begin
            errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, dq_if.out_valid, exp_valid());
         end
         checks++;
         if (masked(dq_if.out_data, exp_valid()) !== exp_data()) begin
            errors++; $display("FAIL rand_data[%0d]: got %h expected %h", c, masked(dq_if.out_data, exp_valid()), exp_data());
         end
         checks++;
         if (dq_if.in_ready !== ((DEPTH - mq.size()) >= N)) begin
            errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, dq_if.in_ready, ((DEPTH - mq.size()) >= N));
         end
`ifdef DISPATCH_QUEUE_STATS_EN
         checks++;
         if (stall_cycles !== 32'(stall_model)) begin
            errors++; $display("FAIL rand_stalls[%0d]: got %0d expected %0d", c, stall_cycles, stall_model);
         end
`endif
      end
      drive(1'b0, 1'b0, 2'b00, '0);
      for (int c = 0; c < 5; c++) tick();
   endtask

`ifdef DISPATCH_QUEUE_STATS_EN
   task automatic test_stats();
      reset_i = 1'b1;
      drive(1'b0, 1'b0, 2'b00, '0);
      #7;
      reset_i = 1'b0;
      mq.delete();
      stall_model = 0;
      @(posedge clock_i); #1;
      drive(1'b0, 1'b1, 2'b11, {rnd64(), rnd64()}); tick();
      drive(1'b0, 1'b1, 2'b00, '0);
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (stall_cycles !== 32'd3) begin errors++; $display("FAIL stats_count: got %0d expected 3", stall_cycles); end
      drive(1'b1, 1'b1, 2'b00, '0); tick();
      drive(1'b0, 1'b0, 2'b00, '0); tick();
      checks++;
      if (stall_cycles !== 32'd3) begin errors++; $display("FAIL stats_squash: got %0d expected 3", stall_cycles); end
   endtask
`endif

   initial begin
      reset_i = 1'b1;
      drive(1'b0, 1'b0, '0, '0);
      test_reset();
      test_fill_and_hold();
      test_single_lane();
      test_squash();
      test_stream();
      test_random();
`ifdef DISPATCH_QUEUE_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
